axi4_mem_subordinate: RTL and testbench



---
 rtl/axi4_pkg.sv | 44 ++++
 rtl/axi4_mem_ram.sv | 31 +++
 rtl/axi4_mem_subordinate.sv | 231 +++++++++++++++++++++++
 tb/tb_axi4_mem_subordinate.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types, FSM state encodings and burst address stepping.
package axi4_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    FIXED      = 2'b00,
    INCR       = 2'b01,
    WRAP       = 2'b10,
    BURST_RSVD = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // Address of the beat following 'addr'; computed at 64 bits so any ADDR_W up to 64 fits.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input burst_t burst);
    logic [63:0] step, aligned, span, base;
    step    = 64'd1 << size;
    aligned = addr & ~(step - 64'd1);
    span    = (64'(len) + 64'd1) << size;
    base    = addr & ~(span - 64'd1);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = base | ((aligned + step) & (span - 64'd1));
      default: next_addr = aligned + step;
    endcase
  endfunction

endpackage

// File: rtl/axi4_mem_ram.sv
// Byte-enable word RAM: one synchronous write port, one combinational read port.
module axi4_mem_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WORDS  = 512,
  parameter int unsigned IDX_W  = 9
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    waddr_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [IDX_W-1:0]    raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [WORDS];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_mem_subordinate.sv
// AXI4 subordinate backed by on-chip RAM; independent write (AW/W/B) and read (AR/R) FSMs.
module axi4_mem_subordinate
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LOG_NB = $clog2(NB);
  localparam int unsigned WORDS  = MEM_BYTES / NB;
  localparam int unsigned IDX_W  = $clog2(WORDS);

  // Transaction response decided at address accept; the highest beat address decides DECERR.
  function automatic resp_t check_resp(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a, step, span, last;
    a    = 64'(addr);
    step = 64'd1 << size;
    span = (64'(len) + 64'd1) << size;
    case (burst_t'(burst))
      INCR:    last = (a & ~(step - 64'd1)) + 64'(len) * step;
      WRAP:    last = (a & ~(span - 64'd1)) + span - step;
      default: last = a;
    endcase
    if (a > last) last = a;
    if (last >= 64'(MEM_BYTES)) return RESP_DECERR;
    if (32'(size) > LOG_NB || burst == 2'b11 ||
        (burst_t'(burst) == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})))
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  wstate_t           w_state_q, w_state_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, waddr_nxt;
  logic [7:0]        awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic [2:0]        awsize_q, awsize_d;
  burst_t            awburst_q, awburst_d;
  resp_t             wresp_q, wresp_d;
  logic              ram_we;

  rstate_t           r_state_q, r_state_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, rd_addr;
  logic [7:0]        arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic [2:0]        arsize_q, arsize_d;
  burst_t            arburst_q, arburst_d;
  resp_t             rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, ram_rdata;

  assign waddr_nxt = ADDR_W'(next_addr(64'(waddr_q), awsize_q, awlen_q, awburst_q));
  // In R_IDLE the RAM is addressed by ARADDR so beat 0 is captured at the AR handshake.
  assign rd_addr   = (r_state_q == R_IDLE) ? ARADDR
                   : ADDR_W'(next_addr(64'(raddr_q), arsize_q, arlen_q, arburst_q));

  axi4_mem_ram #(.DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_ram (
    .clk_i   (ACLK),
    .we_i    (ram_we),
    .waddr_i (IDX_W'(waddr_q >> LOG_NB)),
    .wstrb_i (WSTRB),
    .wdata_i (WDATA),
    .raddr_i (IDX_W'(rd_addr >> LOG_NB)),
    .rdata_o (ram_rdata)
  );

  // Write path state and latched AW fields.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      wcnt_q    <= '0;
      awsize_q  <= '0;
      awburst_q <= FIXED;
      wresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      wcnt_q    <= wcnt_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wresp_q   <= wresp_d;
    end
  end

  // Write FSM next state; a beat is written only while the response is still OKAY.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    wcnt_d    = wcnt_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wresp_d   = wresp_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (AWVALID) begin
        awid_d    = AWID;
        waddr_d   = AWADDR;
        awlen_d   = AWLEN;
        awsize_d  = AWSIZE;
        awburst_d = burst_t'(AWBURST);
        wcnt_d    = '0;
        wresp_d   = check_resp(AWADDR, AWLEN, AWSIZE, AWBURST);
        w_state_d = W_DATA;
      end
      W_DATA: if (WVALID) begin
        ram_we = (wresp_q == RESP_OKAY) && (WLAST == (wcnt_q == awlen_q));
        if ((WLAST != (wcnt_q == awlen_q)) && (wresp_q != RESP_DECERR)) wresp_d = RESP_SLVERR;
        waddr_d = waddr_nxt;
        wcnt_d  = wcnt_q + 8'd1;
        if (wcnt_q == awlen_q) w_state_d = W_RESP;
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path state, latched AR fields and registered beat data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      rcnt_q    <= '0;
      arsize_q  <= '0;
      arburst_q <= FIXED;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      rcnt_q    <= rcnt_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read FSM next state; error transactions return zero data on every beat.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    rcnt_d    = rcnt_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (ARVALID) begin
        arid_d    = ARID;
        raddr_d   = ARADDR;
        arlen_d   = ARLEN;
        arsize_d  = ARSIZE;
        arburst_d = burst_t'(ARBURST);
        rcnt_d    = '0;
        rresp_d   = check_resp(ARADDR, ARLEN, ARSIZE, ARBURST);
        rdata_d   = (rresp_d == RESP_OKAY) ? ram_rdata : '0;
        r_state_d = R_DATA;
      end
      R_DATA: if (RREADY) begin
        if (rcnt_q == arlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          raddr_d = rd_addr;
          rcnt_d  = rcnt_q + 8'd1;
          rdata_d = (rresp_q == RESP_OKAY) ? ram_rdata : '0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign AWREADY = !ARESET && (w_state_q == W_IDLE);
  assign WREADY  = !ARESET && (w_state_q == W_DATA);
  assign BVALID  = !ARESET && (w_state_q == W_RESP);
  assign BID     = awid_q;
  assign BRESP   = wresp_q;
  assign ARREADY = !ARESET && (r_state_q == R_IDLE);
  assign RVALID  = !ARESET && (r_state_q == R_DATA);
  assign RLAST   = !ARESET && (r_state_q == R_DATA) && (rcnt_q == arlen_q);
  assign RID     = arid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_mem_subordinate.sv
// Directed bench for axi4_mem_subordinate with B/R scoreboards and a byte memory model.
module tb_axi4_mem_subordinate;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [63:0] WDATA, RDATA;

  always #5 ACLK = ~ACLK;

  axi4_mem_subordinate #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BYTES(4096)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [7:0]  mdl [logic [31:0]];
  logic [63:0] wbeat [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat address for 8-byte beats with an aligned start (wrap start may be anywhere in the window).
  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [1:0] burst,
                                        input int len, input int i);
    logic [31:0] span, base;
    span = 32'(8 * (len + 1));
    base = a - (a % span);
    case (burst)
      2'b00:   return a;
      2'b10:   return base + ((a - base + 32'(8 * i)) % span);
      default: return a + 32'(8 * i);
    endcase
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [7:0] strb,
                          input logic [1:0] exp_resp, input int stall, input bit bad_last);
    b_exp_t e;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    if (exp_resp == 2'b00)
      for (int i = 0; i <= len; i++)
        for (int j = 0; j < 8; j++)
          if (strb[j]) mdl[baddr(addr, burst, len, i) + 32'(j)] = wbeat[i][8*j +: 8];
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'd3; AWBURST = burst; AWVALID = 1'b1;
    chk("awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA = wbeat[i]; WSTRB = strb; WLAST = (i == len) || (bad_last && i == 0); WVALID = 1'b1;
      chk("wready", WREADY, 1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("b_hold_valid", BVALID, 1);
      chk("b_hold_id", BID, bq[0].id);
      chk("b_hold_resp", BRESP, bq[0].resp);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    e = bq.pop_front();
    chk("bvalid", BVALID, 1);
    chk("bid", BID, e.id);
    chk("bresp", BRESP, e.resp);
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_drop", BVALID, 0);
    chk("awready_again", AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [1:0] exp_resp, input int stall);
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] b;
      b = baddr(addr, burst, len, i);
      e.id = id; e.resp = exp_resp; e.last = (i == len); e.data = '0;
      if (exp_resp == 2'b00)
        for (int j = 0; j < 8; j++) e.data[8*j +: 8] = mdl[b + 32'(j)];
      rq.push_back(e);
    end
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'd3; ARBURST = burst; ARVALID = 1'b1;
    chk("arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      for (int s = 0; s < stall; s++) begin
        chk("r_hold_valid", RVALID, 1);
        chk("r_hold_data", RDATA, rq[0].data);
        chk("r_hold_last", RLAST, rq[0].last);
        chk("r_hold_resp", RRESP, rq[0].resp);
        @(negedge ACLK);
      end
      RREADY = 1'b1;
      e = rq.pop_front();
      chk("rvalid", RVALID, 1);
      chk("rid", RID, e.id);
      chk("rdata", RDATA, e.data);
      chk("rresp", RRESP, e.resp);
      chk("rlast", RLAST, e.last);
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk("rvalid_drop", RVALID, 0);
    chk("arready_again", ARREADY, 1);
  endtask

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);     chk("rst_rid", RID, 0);
    chk("rst_rdata", RDATA, 0);     chk("rst_rresp", RRESP, 0);
    chk("rst_rlast", RLAST, 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Single beats, known word at address 0 for the DECERR aliasing check.
    wbeat[0] = 64'h5A5A_0000_1111_A5A5; do_write(4'd0, 32'h0,  0, 2'b01, 8'hFF, 2'b00, 0, 0);
    wbeat[0] = 64'hDEAD_BEEF_CAFE_1234; do_write(4'd1, 32'h40, 0, 2'b01, 8'hFF, 2'b00, 0, 0);
    do_read(4'd1, 32'h40, 0, 2'b01, 2'b00, 0);
    wbeat[0] = 64'h0123_4567_89AB_CDEF; do_write(4'd2, 32'h80, 0, 2'b01, 8'hFF, 2'b00, 0, 0);
    do_read(4'd2, 32'h80, 0, 2'b01, 2'b00, 0);

    // Out of range: DECERR, no write, zero read data.
    wbeat[0] = 64'hFFFF_0000_FFFF_0000; do_write(4'd3, 32'h11000, 0, 2'b01, 8'hFF, 2'b11, 0, 0);
    do_read(4'd3, 32'h11000, 0, 2'b01, 2'b11, 0);
    do_read(4'd4, 32'h0, 0, 2'b01, 2'b00, 0);

    // Partial strobes.
    wbeat[0] = '1; do_write(4'd5, 32'h100, 0, 2'b01, 8'hFF, 2'b00, 0, 0);
    wbeat[0] = '0; do_write(4'd5, 32'h100, 0, 2'b01, 8'h0F, 2'b00, 0, 0);
    do_read(4'd5, 32'h100, 0, 2'b01, 2'b00, 0);
    chk("strb_merge_model", {mdl[32'h107], mdl[32'h106], mdl[32'h105], mdl[32'h104],
                             mdl[32'h103], mdl[32'h102], mdl[32'h101], mdl[32'h100]},
        64'hFFFF_FFFF_0000_0000);

    // INCR bursts, then with BREADY/RREADY stalled.
    for (int i = 0; i < 4; i++) wbeat[i] = 64'(i + 1);
    do_write(4'd6, 32'h200, 3, 2'b01, 8'hFF, 2'b00, 0, 0);
    do_read(4'd6, 32'h200, 3, 2'b01, 2'b00, 0);
    for (int i = 0; i < 4; i++) wbeat[i] = 64'(i + 5) << 32;
    do_write(4'd7, 32'h200, 3, 2'b01, 8'hFF, 2'b00, 3, 0);
    do_read(4'd7, 32'h200, 3, 2'b01, 2'b00, 3);

    // WRAP burst starting mid-window, read back linearly and wrapped.
    for (int i = 0; i < 4; i++) wbeat[i] = 64'hA0A0_0000_0000_0000 | 64'(i);
    do_write(4'd8, 32'h318, 3, 2'b10, 8'hFF, 2'b00, 0, 0);
    do_read(4'd8, 32'h300, 3, 2'b01, 2'b00, 0);
    do_read(4'd9, 32'h318, 3, 2'b10, 2'b00, 0);

    // FIXED burst: the last beat wins.
    for (int i = 0; i < 2; i++) wbeat[i] = 64'hF1 + 64'(i);
    do_write(4'd10, 32'h400, 1, 2'b00, 8'hFF, 2'b00, 0, 0);
    do_read(4'd10, 32'h400, 1, 2'b00, 2'b00, 0);

    // SLVERR cases: reserved burst, bad WRAP length, WLAST mismatch.
    wbeat[0] = '0; do_write(4'd11, 32'h80, 0, 2'b11, 8'hFF, 2'b10, 0, 0);
    do_read(4'd11, 32'h80, 0, 2'b01, 2'b00, 0);
    do_read(4'd12, 32'h80, 0, 2'b11, 2'b10, 0);
    do_read(4'd12, 32'h300, 2, 2'b10, 2'b10, 0);
    wbeat[0] = '0; wbeat[1] = '0; do_write(4'd13, 32'h700, 1, 2'b01, 8'hFF, 2'b10, 0, 1);

    // Reset with both directions mid-burst.
    AWID = 4'd14; AWADDR = 32'h600; AWLEN = 8'd3; AWSIZE = 3'd3; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK); AWVALID = 1'b0;
    WDATA = 64'h77; WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
    @(negedge ACLK); WVALID = 1'b0;
    ARID = 4'd15; ARADDR = 32'h40; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge ACLK); ARVALID = 1'b0;
    chk("pre_rst_rvalid", RVALID, 1);
    chk("pre_rst_wready", WREADY, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_rvalid", RVALID, 0); chk("mid_rst_bvalid", BVALID, 0);
    chk("mid_rst_wready", WREADY, 0); chk("mid_rst_rlast", RLAST, 0);
    chk("mid_rst_rdata", RDATA, 0);   chk("mid_rst_rid", RID, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_wready", WREADY, 0);
    do_read(4'd1, 32'h200, 3, 2'b01, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
